// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multicycle MIPS datapath.
// Sequences instruction fetch, decode, memory access, ALU steering and
// register writeback. Memory is shared between fetch and data access, and
// mem_ready stalls FETCH, MEM_RD and MEM_WR until the access completes.
//
// Ports:
//   clk, reset        : clock (posedge) and synchronous active-high reset
//   opcode[5:0]       : IR[31:26], sampled in DECODE and MEM_ADDR only
//   mem_ready         : memory access completes this cycle
//   pc_write          : unconditional PC load (FETCH gated by mem_ready, JUMP)
//   pc_write_cond     : PC load if ALU zero (BRANCH)
//   i_or_d            : memory address select, 0 = PC, 1 = ALUOut
//   mem_read/mem_write: memory requests, held until mem_ready
//   ir_write          : instruction register enable (FETCH, gated by mem_ready)
//   mem_to_reg        : writeback select, 1 = MDR, 0 = ALUOut
//   reg_dst           : destination select, 1 = rd, 0 = rt
//   reg_write         : register file write enable
//   alu_src_a         : ALU A select, 0 = PC, 1 = A
//   alu_src_b[1:0]    : ALU B select, 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
//   alu_op[1:0]       : 00 = add, 01 = sub, 10 = funct, 11 = add (ADDI)
//   pc_source[1:0]    : 00 = ALU, 01 = ALUOut, 10 = jump target
//   illegal_op        : one-cycle pulse after DECODE sees an undefined opcode
//   state             : current state, for debug
//
// Optional build macro MC_PERF_CNT_EN adds cycle_count[31:0] and
// instr_count[31:0] performance counters.
module multicycle_control #(
  parameter int unsigned STATE_W  = 4,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
`ifdef MC_PERF_CNT_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
`endif
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEM_ADDR = STATE_W'(2),
    MEM_RD   = STATE_W'(3),
    MEM_WB   = STATE_W'(4),
    MEM_WR   = STATE_W'(5),
    R_EXEC   = STATE_W'(6),
    R_WB     = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    JUMP     = STATE_W'(9),
    I_EXEC   = STATE_W'(10),
    I_WB     = STATE_W'(11)
  } state_t;

  // fetch_gate marks FETCH, where ir_write and pc_write follow mem_ready.
  typedef struct packed {
    logic       fetch_gate;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   op_illegal;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch_gate = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src_b  = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
      end
      I_WB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state = FETCH;
    op_illegal = 1'b0;
    case (state_q)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_RTYPE:     next_state = R_EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = I_EXEC;
          default: begin
            next_state = FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   next_state = FETCH;
      MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
      R_EXEC:   next_state = R_WB;
      R_WB:     next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      I_EXEC:   next_state = I_WB;
      I_WB:     next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Control word is registered from the next state, so ctrl_q always equals
  // decode_ctrl(state_q): Moore outputs without a decode path after the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      ctrl_q     <= decode_ctrl(FETCH);
      illegal_op <= 1'b0;
    end else begin
      state_q    <= next_state;
      ctrl_q     <= decode_ctrl(next_state);
      illegal_op <= op_illegal;
    end
  end

  // Write/request strobes are killed combinationally while reset is high so
  // an abandoned instruction cannot write anything.
  assign pc_write      = ~reset & (ctrl_q.pc_write | (ctrl_q.fetch_gate & mem_ready));
  assign ir_write      = ~reset & ctrl_q.fetch_gate & mem_ready;
  assign pc_write_cond = ~reset & ctrl_q.pc_write_cond;
  assign mem_read      = ~reset & ctrl_q.mem_read;
  assign mem_write     = ~reset & ctrl_q.mem_write;
  assign reg_write     = ~reset & ctrl_q.reg_write;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign state         = state_q;

`ifdef MC_PERF_CNT_EN
  // An instruction retires when the FSM re-enters FETCH from any state other
  // than FETCH itself or DECODE (the latter is the illegal-opcode path).
  logic instr_done;
  assign instr_done = (next_state == FETCH) && (state_q != FETCH) && (state_q != DECODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (instr_done) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push
// expected state/controls into a queue; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op),
`ifdef MC_PERF_CNT_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic        ill;
    logic        pchk;
    logic [31:0] cc;
    logic [31:0] ic;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic        pchk;
    logic [31:0] cc;
    logic [31:0] ic;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic stim_done = 1'b0;

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.st = st; v.ill = ill;
    v.pchk = 1'b0; v.cc = '0; v.ic = '0;
    vecs.push_back(v);
  endtask

  task automatic perf_on_last(input logic [31:0] cc, input logic [31:0] ic);
    vec_t v;
    v = vecs.pop_back();
    v.pchk = 1'b1; v.cc = cc; v.ic = ic;
    vecs.push_back(v);
  endtask

  // Control table per state; order:
  // {pcw, pcwc, i_or_d, mrd, mwr, irw, m2r, rdst, rwr, asa, asb[2], aop[2], psrc[2]}
  function automatic logic [15:0] spec_ctrl(input logic [3:0] st, input logic mr,
                                            input logic rst);
    logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rwr = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rwr = 1'b1; rdst = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd9:  begin pcw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      4'd11: rwr = 1'b1;
      default: ;
    endcase
    if (rst) {pcw, pcwc, mrd, mwr, irw, rwr} = '0;
    return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc};
  endfunction

  initial begin
    // reset phase (state already FETCH from pre-roll edges)
    add(1, LW, 1, 0, 0);
    // LW, no waits: 0,1,2,3,4
    add(0, LW, 1, 0, 0); add(0, LW, 1, 1, 0); add(0, LW, 1, 2, 0);
    add(0, LW, 1, 3, 0); add(0, LW, 1, 4, 0);
    // SW with two wait cycles in MEM_WR
    add(0, SW, 1, 0, 0); add(0, SW, 1, 1, 0); add(0, SW, 1, 2, 0);
    add(0, SW, 0, 5, 0); add(0, SW, 0, 5, 0); add(0, SW, 1, 5, 0);
    // BEQ with one fetch wait; mem_ready low in DECODE is ignored
    add(0, BEQ, 0, 0, 0); add(0, BEQ, 1, 0, 0); add(0, BEQ, 0, 1, 0);
    add(0, BEQ, 1, 8, 0);
    // J
    add(0, JMP, 1, 0, 0); add(0, JMP, 1, 1, 0); add(0, JMP, 1, 9, 0);
    // illegal opcode: 0,1,0 with one-cycle illegal_op
    add(0, BAD, 1, 0, 0); add(0, BAD, 1, 1, 0);
    // R-type (mem_ready low in R_EXEC ignored)
    add(0, RT, 1, 0, 1); add(0, RT, 1, 1, 0); add(0, RT, 0, 6, 0);
    add(0, RT, 1, 7, 0);
    // ADDI
    add(0, ADI, 1, 0, 0); add(0, ADI, 1, 1, 0); add(0, ADI, 1, 10, 0);
    add(0, ADI, 1, 11, 0);
    // LW with one wait in MEM_RD
    add(0, LW, 1, 0, 0); add(0, LW, 1, 1, 0); add(0, LW, 1, 2, 0);
    add(0, LW, 0, 3, 0); add(0, LW, 1, 3, 0); add(0, LW, 1, 4, 0);
    // LW abandoned by 3-cycle reset in MEM_RD with mem_ready high
    add(0, LW, 1, 0, 0); add(0, LW, 1, 1, 0); add(0, LW, 1, 2, 0);
    add(1, LW, 1, 3, 0); add(1, LW, 1, 0, 0); add(1, LW, 1, 0, 0);
    // R-type, ADDI, LW back-to-back, no waits
    add(0, RT, 1, 0, 0); perf_on_last(32'd0, 32'd0);
    add(0, RT, 1, 1, 0); add(0, RT, 1, 6, 0); add(0, RT, 1, 7, 0);
    add(0, ADI, 1, 0, 0); add(0, ADI, 1, 1, 0); add(0, ADI, 1, 10, 0);
    add(0, ADI, 1, 11, 0);
    add(0, LW, 1, 0, 0); add(0, LW, 1, 1, 0); add(0, LW, 1, 2, 0);
    add(0, LW, 1, 3, 0); add(0, LW, 1, 4, 0);
    add(0, RT, 1, 0, 0); perf_on_last(32'd13, 32'd3);

    reset = 1'b1; opcode = RT; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      exp_t e;
      #1;
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].mr;
      e.st   = vecs[i].st;
      e.ctrl = spec_ctrl(vecs[i].st, vecs[i].mr, vecs[i].rst);
      e.ill  = vecs[i].ill;
      e.pchk = vecs[i].pchk;
      e.cc   = vecs[i].cc;
      e.ic   = vecs[i].ic;
      exp_q.push_back(e);
      @(posedge clk);
    end
    stim_done = 1'b1;
  end

  initial begin
    int   guard;
    int   idx;
    exp_t e;
    logic [15:0] act;
    guard = 0;
    idx = 0;
    while (!(stim_done && exp_q.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
        checks++;
        if (state !== e.st) begin
          failures++;
          $display("FAIL state[%0d] got=%0d exp=%0d", idx, state, e.st);
        end
        checks++;
        if (act !== e.ctrl) begin
          failures++;
          $display("FAIL ctrl[%0d] state=%0d got=%b exp=%b", idx, e.st, act, e.ctrl);
        end
        checks++;
        if (illegal_op !== e.ill) begin
          failures++;
          $display("FAIL illegal_op[%0d] got=%b exp=%b", idx, illegal_op, e.ill);
        end
`ifdef MC_PERF_CNT_EN
        if (e.pchk) begin
          checks++;
          if (cycle_count !== e.cc) begin
            failures++;
            $display("FAIL cycle_count[%0d] got=%0d exp=%0d", idx, cycle_count, e.cc);
          end
          checks++;
          if (instr_count !== e.ic) begin
            failures++;
            $display("FAIL instr_count[%0d] got=%0d exp=%0d", idx, instr_count, e.ic);
          end
        end
`endif
        idx++;
      end
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout got=%0d_pending exp=0_pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
